// File: rtl/pipe_scroller_if.sv
// Pipe scroller control/obstacle bundle: game control inputs in, pipe
// geometry, run state and score out.
interface pipe_scroller_if;
  logic       start;
  logic       over;
  logic       frame_tick;
  logic [8:0] x_pipe1;
  logic [8:0] x_pipe2;
  logic [8:0] x_pipe3;
  logic [8:0] x_pipe4;
  logic [6:0] y_pipe1;
  logic [6:0] y_pipe2;
  logic [6:0] y_pipe3;
  logic [6:0] y_pipe4;
  logic       running;
  logic       score_pulse;
  logic [7:0] score;

  modport master (
    output start, over, frame_tick,
    input  x_pipe1, x_pipe2, x_pipe3, x_pipe4,
    input  y_pipe1, y_pipe2, y_pipe3, y_pipe4,
    input  running, score_pulse, score
  );

  modport slave (
    input  start, over, frame_tick,
    output x_pipe1, x_pipe2, x_pipe3, x_pipe4,
    output y_pipe1, y_pipe2, y_pipe3, y_pipe4,
    output running, score_pulse, score
  );
endinterface

// File: rtl/pipe_scroller.sv
// Four scrolling pipe obstacles with LFSR gap heights, run/freeze FSM and
// saturating pass score.
module pipe_scroller #(
  parameter int         MOVE_DIV  = 2,
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  parameter int         Y_MIN     = 64
) (
  input logic            clk,
  input logic            reset,
  pipe_scroller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_t;

  localparam logic [3:0] DIV_LAST = 4'(MOVE_DIV - 1);
  localparam logic [8:0] X_WRAP   = 9'd199;
  localparam logic [8:0] X_SCORE  = 9'd44;
  localparam logic [6:0] Y_BASE   = 7'(Y_MIN);
  localparam logic [8:0] X_INIT [4] = '{9'd160, 9'd210, 9'd260, 9'd310};
  localparam logic [6:0] Y_INIT [4] = '{7'd80, 7'd70, 7'd90, 7'd75};

  state_t     state;
  state_t     state_next;
  logic [3:0] div_cnt;
  logic [7:0] lfsr;
  logic [8:0] x_q [4];
  logic [6:0] y_q [4];
  logic       running_q;
  logic       score_pulse_q;
  logic [7:0] score_q;

  logic       load_game;
  logic       step_en;
  logic       move;
  logic       hit;
  logic       lfsr_fb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (bus.over)  state_next = FROZEN;
      FROZEN:  if (bus.start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Collision freeze takes priority over a due move: no step, no divider advance.
  always_comb begin
    load_game = 1'b0;
    step_en   = 1'b0;
    move      = 1'b0;
    case (state)
      IDLE, FROZEN: load_game = bus.start;
      RUN: begin
        step_en = bus.frame_tick && !bus.over;
        move    = step_en && (div_cnt == DIV_LAST);
      end
      default: ;
    endcase
  end

  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (x_q[i] == X_SCORE) hit = 1'b1;
    end
  end

  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr          <= LFSR_SEED;
      div_cnt       <= '0;
      running_q     <= 1'b0;
      score_pulse_q <= 1'b0;
      score_q       <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        x_q[i] <= X_INIT[i];
        y_q[i] <= Y_INIT[i];
      end
    end else begin
      lfsr          <= {lfsr[6:0], lfsr_fb};
      running_q     <= (state_next == RUN);
      score_pulse_q <= 1'b0;
      if (load_game) begin
        div_cnt <= '0;
        score_q <= '0;
        for (int unsigned i = 0; i < 4; i++) begin
          x_q[i] <= X_INIT[i];
          y_q[i] <= Y_INIT[i];
        end
      end else if (step_en) begin
        if (move) begin
          div_cnt <= '0;
          for (int unsigned i = 0; i < 4; i++) begin
            if (x_q[i] == '0) begin
              x_q[i] <= X_WRAP;
              y_q[i] <= Y_BASE + {2'b00, lfsr[4:0]};
            end else begin
              x_q[i] <= x_q[i] - 9'd1;
            end
          end
          if (hit) begin
            score_pulse_q <= 1'b1;
            if (score_q != '1) score_q <= score_q + 8'd1;
          end
        end else begin
          div_cnt <= div_cnt + 4'd1;
        end
      end
    end
  end

  assign bus.x_pipe1     = x_q[0];
  assign bus.x_pipe2     = x_q[1];
  assign bus.x_pipe3     = x_q[2];
  assign bus.x_pipe4     = x_q[3];
  assign bus.y_pipe1     = y_q[0];
  assign bus.y_pipe2     = y_q[1];
  assign bus.y_pipe3     = y_q[2];
  assign bus.y_pipe4     = y_q[3];
  assign bus.running     = running_q;
  assign bus.score_pulse = score_pulse_q;
  assign bus.score       = score_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// Randomized bench for pipe_scroller against a behavioural game model,
// plus literal checks of reset, scroll, wrap, score, freeze and async reset.
module tb_pipe_scroller;

  localparam int         MOVE_DIV  = 2;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam int         Y_MIN     = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipe_scroller_if bus();

  pipe_scroller #(.MOVE_DIV(MOVE_DIV), .LFSR_SEED(LFSR_SEED), .Y_MIN(Y_MIN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_chk  = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: a game is either playing or waiting for start; idle and frozen
  // behave identically apart from what they were reached from.
  int         mx [4];
  int         my [4];
  bit         m_run;
  int         m_score;
  bit         m_pulse;
  int         m_div;
  logic [7:0] m_lfsr;

  task automatic model_load();
    mx = '{160, 210, 260, 310};
    my = '{80, 70, 90, 75};
    m_score = 0;
    m_div = 0;
  endtask

  always @(posedge clk or posedge reset) begin
    logic [7:0] cur;
    bit p;
    if (reset) begin
      model_load();
      m_run = 1'b0;
      m_pulse = 1'b0;
      m_lfsr = LFSR_SEED;
    end else begin
      cur = m_lfsr;
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
      p = 1'b0;
      if (!m_run) begin
        if (bus.start) begin
          model_load();
          m_run = 1'b1;
        end
      end else if (bus.over) begin
        m_run = 1'b0;
      end else if (bus.frame_tick) begin
        m_div++;
        if (m_div == MOVE_DIV) begin
          m_div = 0;
          for (int i = 0; i < 4; i++) begin
            if (mx[i] == 44) p = 1'b1;
            if (mx[i] == 0) begin
              mx[i] = 199;
              my[i] = Y_MIN + int'(cur) % 32;
            end else begin
              mx[i] = mx[i] - 1;
            end
          end
          if (p && m_score < 255) m_score++;
        end
      end
      m_pulse = p;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("x_pipe1", int'(bus.x_pipe1), mx[0]);
        chk("x_pipe2", int'(bus.x_pipe2), mx[1]);
        chk("x_pipe3", int'(bus.x_pipe3), mx[2]);
        chk("x_pipe4", int'(bus.x_pipe4), mx[3]);
        chk("y_pipe1", int'(bus.y_pipe1), my[0]);
        chk("y_pipe2", int'(bus.y_pipe2), my[1]);
        chk("y_pipe3", int'(bus.y_pipe3), my[2]);
        chk("y_pipe4", int'(bus.y_pipe4), my[3]);
        chk("running", int'(bus.running), int'(m_run));
        chk("score_pulse", int'(bus.score_pulse), int'(m_pulse));
        chk("score", int'(bus.score), m_score);
      end
    end
  end

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic do_ticks(input int n, input bit rnd_start);
    for (int k = 0; k < n; k++) begin
      int g;
      g = $urandom_range(0, 2);
      for (int j = 0; j < g; j++) begin
        bus.start = rnd_start && ($urandom_range(0, 7) == 0);
        @(negedge clk);
      end
      bus.start = 1'b0;
      bus.frame_tick = 1'b1;
      @(negedge clk);
      bus.frame_tick = 1'b0;
    end
  endtask

  initial begin
    int sx;
    int budget;
    bus.start = 1'b0;
    bus.over = 1'b0;
    bus.frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cmp_en = 1'b1;

    // Idle after reset
    repeat (20) @(negedge clk);
    chk("idle_x1", int'(bus.x_pipe1), 160);
    chk("idle_x2", int'(bus.x_pipe2), 210);
    chk("idle_x3", int'(bus.x_pipe3), 260);
    chk("idle_x4", int'(bus.x_pipe4), 310);
    chk("idle_y1", int'(bus.y_pipe1), 80);
    chk("idle_y2", int'(bus.y_pipe2), 70);
    chk("idle_y3", int'(bus.y_pipe3), 90);
    chk("idle_y4", int'(bus.y_pipe4), 75);
    chk("idle_running", int'(bus.running), 0);
    chk("idle_score", int'(bus.score), 0);

    // Start and scroll
    pulse_start();
    chk("start_running", int'(bus.running), 1);
    do_ticks(4, 1'b1);
    chk("t4_x1", int'(bus.x_pipe1), 158);
    chk("t4_x4", int'(bus.x_pipe4), 308);
    do_ticks(230, 1'b1);
    chk("t234_x1", int'(bus.x_pipe1), 43);
    chk("t234_score", int'(bus.score), 1);
    do_ticks(86, 1'b1);
    chk("t320_x1", int'(bus.x_pipe1), 0);
    do_ticks(2, 1'b1);
    chk("t322_x1", int'(bus.x_pipe1), 199);
    chk("wrap_y1_range", int'(bus.y_pipe1 >= 7'd64 && bus.y_pipe1 <= 7'd95), 1);
    do_ticks(212, 1'b1);
    chk("t534_score", int'(bus.score), 4);

    // Freeze on a due move
    budget = 0;
    while (m_div != MOVE_DIV - 1 && budget < 8) begin
      do_ticks(1, 1'b0);
      budget++;
    end
    chk("due_move_reached", int'(m_div == MOVE_DIV - 1), 1);
    sx = int'(bus.x_pipe1);
    bus.over = 1'b1;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.over = 1'b0;
    bus.frame_tick = 1'b0;
    chk("freeze_x1", int'(bus.x_pipe1), sx);
    chk("freeze_running", int'(bus.running), 0);
    for (int k = 0; k < 6; k++) begin
      bus.over = 1'($urandom_range(0, 1));
      do_ticks(1, 1'b0);
    end
    chk("frozen_x1", int'(bus.x_pipe1), sx);
    bus.over = 1'b1;
    pulse_start();
    chk("restart_x1", int'(bus.x_pipe1), 160);
    chk("restart_x4", int'(bus.x_pipe4), 310);
    chk("restart_running", int'(bus.running), 1);
    @(negedge clk);
    bus.over = 1'b0;
    chk("over_after_restart", int'(bus.running), 0);

    // Random play
    for (int c = 0; c < 3000; c++) begin
      bus.frame_tick = 1'($urandom_range(0, 1));
      bus.start = ($urandom_range(0, 49) == 0);
      bus.over = ($urandom_range(0, 32) == 0);
      @(negedge clk);
    end
    bus.frame_tick = 1'b0;
    bus.start = 1'b0;
    bus.over = 1'b0;
    @(negedge clk);

    // Long run to score saturation
    if (!m_run) pulse_start();
    bus.frame_tick = 1'b1;
    for (int c = 0; c < 27200; c++) begin
      bus.start = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("sat_score", int'(bus.score), 255);
    chk("sat_running", int'(bus.running), 1);

    // Asynchronous reset between edges
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("areset_x1", int'(bus.x_pipe1), 160);
    chk("areset_x4", int'(bus.x_pipe4), 310);
    chk("areset_y2", int'(bus.y_pipe2), 70);
    chk("areset_running", int'(bus.running), 0);
    chk("areset_pulse", int'(bus.score_pulse), 0);
    chk("areset_score", int'(bus.score), 0);
    bus.frame_tick = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_reset_idle_x1", int'(bus.x_pipe1), 160);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
